// File: rtl/goertzel_bin_engine.sv
// -----------------------------------------------------------------------------
// goertzel_bin_engine
//
// Single-bin Goertzel engine. For each processing block it requests one
// sin/cos coefficient pair from the upstream feeder, captures it, runs the
// second-order Goertzel recursion over N_SAMPLES qualified samples, and then
// emits the complex bin result with a one-cycle valid strobe.
//
// Ports:
//   sys_clk    : system clock, rising edge
//   rst        : synchronous active-high reset
//   enable     : level; blocks run back to back while high
//   coeffs_rq  : one-cycle coefficient request to the feeder
//   d_ready    : feeder acknowledge (only honoured while waiting for it)
//   sin_in     : sin(w), signed Q1.14
//   cos_in     : cos(w), signed Q1.14
//   smp_in     : signed sample
//   smp_valid  : sample qualifier
//   smp_drop   : registered pulse for a valid sample seen outside accumulation
//   re_out     : real part of the bin result
//   im_out     : imaginary part of the bin result
//   res_valid  : one-cycle result strobe; re_out/im_out hold until the next
//   busy       : high whenever the engine is not idle
// -----------------------------------------------------------------------------
module goertzel_bin_engine #(
    parameter int D_W       = 16,
    parameter int ACC_W     = 32,
    parameter int N_SAMPLES = 205,
    parameter int CNT_W     = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             enable,
    output logic             coeffs_rq,
    input  logic             d_ready,
    input  logic [D_W-1:0]   sin_in,
    input  logic [D_W-1:0]   cos_in,
    input  logic [D_W-1:0]   smp_in,
    input  logic             smp_valid,
    output logic             smp_drop,
    output logic [ACC_W-1:0] re_out,
    output logic [ACC_W-1:0] im_out,
    output logic             res_valid,
    output logic             busy
);

    localparam int PROD_W = D_W + ACC_W;
    // Coefficients are Q1.14: a shift of FRAC_W scales by cos(w), while the
    // recursion needs 2*cos(w), hence one bit less of shift there.
    localparam int FRAC_W = 14;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_LATCH, S_ACC, S_FIN1, S_FIN2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [D_W-1:0]   sin_q, sin_d, cos_q, cos_d;
    logic signed [ACC_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic signed [ACC_W-1:0] pc_q, pc_d, ps_q, ps_d;
    logic [ACC_W-1:0]        re_q, re_d, im_q, im_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    coeffs_rq_q, coeffs_rq_d;
    logic                    smp_drop_q, smp_drop_d;
    logic                    res_valid_q, res_valid_d;
    logic                    busy_q, busy_d;

    // Full-width signed products; operands are sign-extended to PROD_W so the
    // low PROD_W bits of each product are exact.
    logic signed [PROD_W-1:0] cos_ext, sin_ext, s1_ext, s2_ext;
    logic signed [PROD_W-1:0] fb_sh, pc_sh, ps_sh;
    logic [ACC_W-1:0]         x_ext, s0;
    logic                     unused_prod_hi;

    always_comb begin
        cos_ext = {{ACC_W{cos_q[D_W-1]}}, cos_q};
        sin_ext = {{ACC_W{sin_q[D_W-1]}}, sin_q};
        s1_ext  = {{D_W{s1_q[ACC_W-1]}}, s1_q};
        s2_ext  = {{D_W{s2_q[ACC_W-1]}}, s2_q};
        fb_sh   = (cos_ext * s1_ext) >>> (FRAC_W - 1);
        pc_sh   = (cos_ext * s2_ext) >>> FRAC_W;
        ps_sh   = (sin_ext * s2_ext) >>> FRAC_W;
        x_ext   = {{(ACC_W-D_W){smp_in[D_W-1]}}, smp_in};
        // Sums wrap in ACC_W bits by design; no saturation.
        s0      = x_ext + fb_sh[ACC_W-1:0] - s2_q;
    end

    // Upper product bits are discarded by the truncation to ACC_W.
    assign unused_prod_hi = ^{fb_sh[PROD_W-1:ACC_W], pc_sh[PROD_W-1:ACC_W],
                              ps_sh[PROD_W-1:ACC_W]};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        pc_d        = pc_q;
        ps_d        = ps_q;
        re_d        = re_q;
        im_d        = im_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;

        case (state_q)
            S_IDLE:  if (enable) state_d = S_REQ;
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  if (d_ready) state_d = S_LATCH;
            // Capture one edge after d_ready to cover the feeder's BRAM latency.
            S_LATCH: begin
                sin_d   = sin_in;
                cos_d   = cos_in;
                s1_d    = '0;
                s2_d    = '0;
                cnt_d   = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (smp_valid) begin
                    s2_d  = s1_q;
                    s1_d  = s0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = S_FIN1;
                end
            end
            S_FIN1: begin
                pc_d    = pc_sh[ACC_W-1:0];
                ps_d    = ps_sh[ACC_W-1:0];
                state_d = S_FIN2;
            end
            S_FIN2: begin
                re_d        = s1_q - pc_q;
                im_d        = ps_q;
                res_valid_d = 1'b1;
                state_d     = enable ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from the next state so the request lines up with REQ.
        coeffs_rq_d = (state_d == S_REQ);
        busy_d      = (state_d != S_IDLE);
        smp_drop_d  = smp_valid && (state_q != S_ACC);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sin_q       <= '0;
            cos_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            pc_q        <= '0;
            ps_q        <= '0;
            re_q        <= '0;
            im_q        <= '0;
            cnt_q       <= '0;
            coeffs_rq_q <= 1'b0;
            smp_drop_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            pc_q        <= pc_d;
            ps_q        <= ps_d;
            re_q        <= re_d;
            im_q        <= im_d;
            cnt_q       <= cnt_d;
            coeffs_rq_q <= coeffs_rq_d;
            smp_drop_q  <= smp_drop_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign coeffs_rq = coeffs_rq_q;
    assign smp_drop  = smp_drop_q;
    assign re_out    = re_q;
    assign im_out    = im_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule
